// File: rtl/debug_initiator.sv
// debug_initiator: single-outstanding bus initiator driving the core debug port from a host cmd/rsp channel
// Ports: clk_i/rst_i (sync, active high); cmd_* host command channel (valid/ready);
//        rsp_* host response channel (valid/ready, rdata, err=timeout);
//        debug_* request/grant/rvalid transaction towards the core debug unit.
module debug_initiator #(
   parameter int unsigned DBG_ADDR_WIDTH = 15,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_we_i,
   input  logic [DBG_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]               cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      debug_req_o,
   input  logic                      debug_gnt_i,
   input  logic                      debug_rvalid_i,
   output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
   output logic                      debug_we_o,
   output logic [31:0]               debug_wdata_o,
   input  logic [31:0]               debug_rdata_i
);
   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, RESP} state_t;
   state_t                    state_q, state_d;
   logic                      req_q, req_d, we_q, we_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
   logic [DBG_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      tmo;
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      // the counter compares before this cycle's increment, so the req is visible TIMEOUT_CYCLES cycles
      tmo         = TMO_EN && (cnt_q >= CNT_LAST);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cmd_valid_i) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = cmd_we_i;
               addr_d  = cmd_addr_i;
               wdata_d = cmd_we_i ? cmd_wdata_i : '0;
            end
         end
         REQ: begin
            if (debug_gnt_i) begin
               req_d = 1'b0;
               if (debug_rvalid_i) begin
                  state_d     = RESP;
                  rdata_d     = we_q ? '0 : debug_rdata_i;
                  err_d       = 1'b0;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d = WAIT_RV;
               end
            end else if (tmo) begin
               state_d     = RESP;
               req_d       = 1'b0;
               rdata_d     = '0;
               err_d       = 1'b1;
               rsp_valid_d = 1'b1;
            end
         end
         WAIT_RV: begin
            if (debug_rvalid_i) begin
               state_d     = RESP;
               rdata_d     = we_q ? '0 : debug_rdata_i;
               err_d       = 1'b0;
               rsp_valid_d = 1'b1;
            end else if (tmo) begin
               state_d     = RESP;
               rdata_d     = '0;
               err_d       = 1'b1;
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            cnt_d = cnt_q;
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         cnt_q       <= cnt_d;
      end
   end
   assign cmd_ready_o   = (state_q == IDLE);
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = err_q;
   assign debug_req_o   = req_q;
   assign debug_addr_o  = addr_q;
   assign debug_we_o    = we_q;
   assign debug_wdata_o = wdata_q;
endmodule

// File: tb/tb_debug_initiator.sv
// tb_debug_initiator: directed timeline-model bench for debug_initiator
module tb_debug_initiator;
   localparam int T = 8;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0, rsp_ready_i = 1'b0;
   logic        debug_gnt_i = 1'b0, debug_rvalid_i = 1'b0;
   logic [14:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0, debug_rdata_i = '0;
   logic        cmd_ready_o, rsp_valid_o, rsp_err_o, debug_req_o, debug_we_o;
   logic [31:0] rsp_rdata_o, debug_wdata_o;
   logic [14:0] debug_addr_o;
   debug_initiator #(.DBG_ADDR_WIDTH(15), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i),
      .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o), .debug_wdata_o(debug_wdata_o),
      .debug_rdata_i(debug_rdata_i)
   );
   always #5 clk_i = ~clk_i;
   int          vecs = 0, errs = 0;
   logic        chk_en = 1'b0, chk_addr = 1'b0;
   logic        e_ready = 1'b1, e_req = 1'b0, e_rsp = 1'b0, e_we = 1'b0, e_err = 1'b0;
   logic [14:0] e_addr = '0;
   logic [31:0] e_wdata = '0, e_rdata = '0;
   int          cyc = 0, acc_cyc = 0, lat = 0, req_n = 0;
   logic        rsp_seen = 1'b0, cap_err = 1'b0;
   logic [31:0] cap_rdata = '0;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask
   always @(negedge clk_i) begin
      cyc++;
      if (chk_en) begin
         chk("cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
         chk("debug_req", 32'(debug_req_o), 32'(e_req));
         chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
         if (chk_addr) begin
            chk("debug_addr", 32'(debug_addr_o), 32'(e_addr));
            chk("debug_we", 32'(debug_we_o), 32'(e_we));
            chk("debug_wdata", debug_wdata_o, e_wdata);
         end
         if (e_rsp) begin
            chk("rsp_rdata", rsp_rdata_o, e_rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
         end
      end
      if (cmd_valid_i && cmd_ready_o) begin
         acc_cyc  = cyc;
         req_n    = 0;
         rsp_seen = 1'b0;
      end
      if (debug_req_o) req_n++;
      if (rsp_valid_o && !rsp_seen) begin
         rsp_seen  = 1'b1;
         lat       = cyc - acc_cyc;
         cap_rdata = rsp_rdata_o;
         cap_err   = rsp_err_o;
      end
   end
   // Cycle 0 is the accept cycle; the core grants in cycle g and answers in cycle r.
   // Done cycle d: r if both land within the timeout window, else T. Response shows from d+1
   // and is held h cycles before the host takes it.
   task automatic txn(input logic we, input logic [14:0] a, input logic [31:0] wd,
                      input int g, input int r, input logic [31:0] rd, input int h);
      int   d;
      logic err;
      if (g <= T && r <= T) begin d = r; err = 1'b0; end
      else begin d = T; err = 1'b1; end
      for (int c = 0; c <= d + 1 + h; c++) begin
         cmd_valid_i    = (c == 0);
         cmd_we_i       = (c == 0) ? we : ~we;
         cmd_addr_i     = (c == 0) ? a : ~a;
         cmd_wdata_i    = (c == 0) ? wd : ~wd;
         debug_gnt_i    = (c == g);
         debug_rvalid_i = (c == r);
         debug_rdata_i  = (c == r) ? rd : 32'h0BAD_0BAD;
         rsp_ready_i    = (c == d + 1 + h);
         e_ready        = (c == 0);
         e_req          = (c >= 1) && (c <= ((g < d) ? g : d));
         e_rsp          = (c > d);
         e_err          = err;
         e_rdata        = (err || we) ? 32'h0 : rd;
         e_we           = we;
         e_addr         = a;
         e_wdata        = we ? wd : 32'h0;
         chk_addr       = (c >= 1);
         @(posedge clk_i); #1;
      end
      cmd_valid_i = 1'b0; debug_gnt_i = 1'b0; debug_rvalid_i = 1'b0; rsp_ready_i = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
      chk("rst_req", 32'(debug_req_o), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_rdata", rsp_rdata_o, 32'h0);
      chk("rst_err", 32'(rsp_err_o), 32'h0);
      chk("rst_addr", 32'(debug_addr_o), 32'h0);
      chk("rst_wdata", debug_wdata_o, 32'h0);
      e_ready = 1'b1; e_req = 1'b0; e_rsp = 1'b0; chk_addr = 1'b1;
      chk_en = 1'b1;
      @(posedge clk_i); #1;
      txn(1'b0, 15'h2000, 32'h0, 1, 2, 32'hDEAD_BEEF, 0);
      chk("t1_latency", 32'(lat), 32'd3);
      chk("t1_req_cycles", 32'(req_n), 32'd1);
      chk("t1_rdata", cap_rdata, 32'hDEAD_BEEF);
      txn(1'b1, 15'h0004, 32'h1234_5678, 6, 7, 32'h5555_AAAA, 0);
      chk("t2_req_cycles", 32'(req_n), 32'd6);
      chk("t2_rdata", cap_rdata, 32'h0);
      chk("t2_err", 32'(cap_err), 32'h0);
      txn(1'b0, 15'h0123, 32'h0, 1, 1, 32'hA5A5_A5A5, 0);
      chk("t3_latency", 32'(lat), 32'd2);
      chk("t3_rdata", cap_rdata, 32'hA5A5_A5A5);
      txn(1'b0, 15'h7FFF, 32'h0, 1000, 10, 32'h7777_7777, 3);
      chk("t4_req_cycles", 32'(req_n), 32'd8);
      chk("t4_err", 32'(cap_err), 32'h1);
      chk("t4_rdata", cap_rdata, 32'h0);
      txn(1'b0, 15'h0042, 32'h0, 2, 3, 32'hCAFE_F00D, 0);
      chk("t4_next_rdata", cap_rdata, 32'hCAFE_F00D);
      chk("t4_next_err", 32'(cap_err), 32'h0);
      txn(1'b0, 15'h0100, 32'h0, 1, 2, 32'h1357_9BDF, 10);
      chk("t5_latency", 32'(lat), 32'd3);
      txn(1'b1, 15'h0008, 32'hFEED_0001, 1, 1, 32'hFFFF_FFFF, 1);
      chk("wr_same_rdata", cap_rdata, 32'h0);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 15'h1111; cmd_wdata_i = 32'h0;
      e_ready = 1'b1; e_req = 1'b0; e_rsp = 1'b0; chk_addr = 1'b0;
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      e_ready = 1'b0; e_req = 1'b1; chk_addr = 1'b1; e_addr = 15'h1111; e_we = 1'b0; e_wdata = 32'h0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      e_ready = 1'b1; e_req = 1'b0; e_rsp = 1'b0; e_addr = 15'h0;
      chk("t6_req", 32'(debug_req_o), 32'h0);
      chk("t6_cmd_ready", 32'(cmd_ready_o), 32'h1);
      @(posedge clk_i); #1;
      txn(1'b0, 15'h2222, 32'h0, 1, 2, 32'h0F0F_1234, 0);
      chk("t6_next_rdata", cap_rdata, 32'h0F0F_1234);
      chk("t6_next_latency", 32'(lat), 32'd3);
      e_ready = 1'b1; e_req = 1'b0; e_rsp = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
